mux_nway_arb: RTL
=================

Name: mux_nway_arb

Overview:
- Parametrised successor to the fixed 4-way/16-bit combinational selector.
- Selects one of CHANNELS input streams of WIDTH bits and registers the chosen word into a one-entry output stage with a valid/ready handshake.
- Two selection modes:
  - Fixed: the channel is given by `sel`.
  - Round-robin: rotating-priority arbitration among channels whose valid is high.
- Sits between multiple producers (register/ALU/memory read paths) and a single consumer, for example a bus or writeback port.

Parameters:
- WIDTH, 16, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, derived as clog2(CHANNELS), channel-index width; not overridden by users.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data valid.
- in_ready  output  CHANNELS  per-channel accept; one-hot or zero.
- sel  input  SEL_W  channel index used in fixed mode.
- rr_en  input  1  0 = fixed mode, 1 = round-robin mode.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset: sync, active-high, on clk rising edge. After reset:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=0.
  - Any held word is discarded; no in_ready is asserted during the rst cycle.
- Load condition: can_load = !out_valid || out_ready. The output stage sustains one word per cycle under continuous out_ready=1.
- Fixed mode (rr_en=0):
  - grant index g = sel; a grant exists iff sel < CHANNELS.
  - in_ready[sel] = can_load, independent of in_valid. All other in_ready bits are 0.
- Round-robin mode (rr_en=1):
  - g = first i with in_valid[i]=1, scanning ptr, ptr+1, ... mod CHANNELS.
  - A grant exists iff |in_valid. Only in_ready[g] = can_load.
- Transfer: occurs when a grant exists and in_valid[g] && in_ready[g]. On the next edge:
  - out_data <= channel g data; out_chan <= g; out_valid <= 1.
  - In round-robin mode only, ptr <= (g+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
- Drain: if out_valid && out_ready && no transfer, then out_valid <= 0. out_data and out_chan hold their last values.
- Stall: if out_valid && !out_ready, out_data, out_chan and out_valid hold stable, and all in_ready = 0.
- Latency: a word accepted at edge N appears on out_data after edge N. Combinational path from in_valid/out_ready to in_ready is allowed; no combinational path from in_data to out_data.
- ptr is not modified in fixed mode. On a rr_en 0->1 change, arbitration resumes from the retained ptr.
- sel >= CHANNELS (CHANNELS not a power of 2): no grant, all in_ready = 0, output drains normally.
- Simultaneous drain and load in one cycle: the new word replaces the old one; out_valid stays 1 with no bubble.
- rst asserted mid-transfer takes priority over everything: the word is lost and the producer must not consider it accepted.

Decomposition:
- Shared package mux_pkg holds:
  - the clog2 constant function;
  - the MODE_FIXED=0 / MODE_RR=1 constants;
  - the channel-slice helper macro/function for flattened buses.
- One natural sub-module: rr_arbiter (CHANNELS param). It takes req, ptr and en, and returns a one-hot grant, a grant index and a found flag. It is purely combinational; ptr stays in the parent.
- The data path (indexed slice plus output register) stays in mux_nway_arb.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with all in_valid=1 and out_ready=1 -> out_valid=0, out_data=0x0000, out_chan=0, in_ready=0000 during rst.
2. Fixed mode, default params: rr_en=0, sel=2, in_valid=1111, channel data 0x1111/0x2222/0x3333/0x4444, out_ready=1 -> in_ready=0100, and one cycle later out_data=0x3333, out_chan=2, continuing every cycle.
3. Round-robin fairness: rr_en=1, in_valid=1111 held, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with no bubbles.
4. Round-robin skip and wrap: ptr=3 (after a grant to 2), in_valid=0011 -> grant 0, then 1, then 0; ptr wraps 3->... ->1->2->1.
5. Backpressure: out_valid=1 holding 0xBEEF, out_ready=0 for 3 cycles with inputs valid -> out_data stays 0xBEEF, in_ready=0000. When out_ready=1, the next word loads in the same cycle and out_valid stays 1.
6. CHANNELS=3, WIDTH=8: sel=3 in fixed mode -> in_ready=000 and the held word drains. Then rst asserted while out_valid=1 -> out_valid=0 the next cycle and ptr=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N-way selector: index-width helper, mode encoding
// and the flattened-bus lane accessor.
`ifndef MUX_PKG_SV
`define MUX_PKG_SV

// Lane idx of a flattened bus whose lanes are w bits wide.
`define MUX_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package mux_pkg;

   localparam logic MODE_FIXED   = 1'b0;
   localparam logic MODE_RR      = 1'b1;
   localparam int   MAX_CHANNELS = 16;

   // Ceiling log2 used to size channel indices.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

`endif

// File: rtl/rr_arbiter.sv
// Rotating-priority request picker: scans req starting at ptr and returns the
// first requester as a one-hot grant plus its index.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int SEL_W    = clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   input  logic                en,
   output logic [CHANNELS-1:0] gnt,
   output logic [SEL_W-1:0]    gnt_idx,
   output logic                found
);

   int c;

   // NOTE: every output is given a default before the scan so the block
   // cannot infer a latch on the paths where no requester is found.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      c       = 0;
      if (en) begin
         for (int k = 0; k < CHANNELS; k++) begin
            c = int'(ptr) + k;
            if (c >= CHANNELS) c = c - CHANNELS;
            if (!found && req[c]) begin
               found   = 1'b1;
               gnt[c]  = 1'b1;
               gnt_idx = SEL_W'(c);
            end
         end
      end
   end

endmodule

// File: rtl/mux_nway_arb.sv
// CHANNELS-way selector with fixed or round-robin channel choice feeding a
// one-entry registered output stage with valid/ready handshake.
module mux_nway_arb
   import mux_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = clog2(CHANNELS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS*WIDTH-1:0]    in_data,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   input  logic [SEL_W-1:0]             sel,
   input  logic                         rr_en,
   output logic [WIDTH-1:0]             out_data,
   output logic [SEL_W-1:0]             out_chan,
   output logic                         out_valid,
   input  logic                         out_ready
);

   logic                can_load;
   logic                rr_mode;
   logic [CHANNELS-1:0] fix_gnt;
   logic [CHANNELS-1:0] rr_gnt;
   logic [CHANNELS-1:0] gnt;
   logic [SEL_W-1:0]    rr_idx;
   logic [SEL_W-1:0]    gnt_idx;
   logic                rr_found;
   logic                xfer;
   logic [WIDTH-1:0]    sel_data;
   logic [SEL_W-1:0]    ptr;
   logic [SEL_W-1:0]    ptr_next;

   assign rr_mode  = (rr_en == MODE_RR);
   assign can_load = !out_valid || out_ready;

   // An out-of-range sel decodes to no grant at all.
   always_comb begin
      fix_gnt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         fix_gnt[i] = (sel == SEL_W'(i));
      end
   end

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_arb (
      .req     (in_valid),
      .ptr     (ptr),
      .en      (rr_mode),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .found   (rr_found)
   );

   assign gnt      = rr_mode ? rr_gnt : fix_gnt;
   assign gnt_idx  = rr_mode ? rr_idx : sel;
   assign in_ready = (can_load && !rst) ? gnt : '0;
   assign xfer     = |(in_ready & in_valid);
   assign ptr_next = (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;

   // One-hot AND-OR mux keeps the data path free of a wide variable shifter.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (gnt[i]) sel_data = sel_data | `MUX_SLICE(in_data, i, WIDTH);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_chan  <= gnt_idx;
         if (rr_mode) ptr <= ptr_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // rr_found is implied by a nonzero rr_gnt; keep it observable for reuse.
   logic unused_found;
   assign unused_found = rr_found;

endmodule
